// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_slave_pkg
// Brief   : Shared FSM encoding, frame geometry and address helper for the
//           SPI slave register file.
// Revision: 1.0 - initial release
// ============================================================================
package spi_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int          c_BYTE_BITS  = 8;
    localparam int          c_FRAME_BITS = 16;
    localparam int          c_RW_POS     = 7;
    localparam int          c_ADDR_W     = 7;
    localparam logic [3:0]  c_CMD_LAST   = 4'(c_BYTE_BITS - 1);
    localparam logic [3:0]  c_FRAME_LAST = 4'(c_FRAME_BITS - 1);

    function automatic logic addr_ok(input logic [c_ADDR_W-1:0] a, input int n);
        return int'(a) < n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : spi_sync_edge
// Brief   : Flop-chain synchronizer with single-cycle rise/fall pulses taken
//           from the synchronized level.
// Revision: 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RST_LEVEL = 1'b0
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] r_chain;
    logic              r_prev;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_chain <= {STAGES{RST_LEVEL}};
            r_prev  <= RST_LEVEL;
        end else begin
            r_chain[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
            r_prev <= r_chain[STAGES-1];
        end
    end

    assign dout = r_chain[STAGES-1];
    assign rise = dout & ~r_prev;
    assign fall = ~dout & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave_rf.sv
`default_nettype none
// ============================================================================
// Module  : spi_slave_rf
// Brief   : Mode-0 SPI slave giving a master 16-bit-frame read/write access
//           to a bank of 8-bit registers, with a local read port.
// Revision: 1.0 - initial release
// ============================================================================
module spi_slave_rf
    import spi_slave_pkg::*;
#(
    parameter int         NREG        = 16,
    parameter logic [7:0] RST_VAL     = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic                spi_sck,
    input  logic                spi_mosi,
    input  logic                spi_cs,
    output logic                spi_miso_out,
    output logic                spi_miso_oe,
    output logic                wr_valid,
    output logic [c_ADDR_W-1:0] wr_addr,
    output logic [7:0]          wr_data,
    output logic                rd_valid,
    output logic                frame_err,
    input  logic [c_ADDR_W-1:0] lcl_addr,
    output logic [7:0]          lcl_rdata
);

    localparam int c_IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    state_t                r_state, w_state_nxt;
    logic                  w_sck_rise, w_sck_fall, w_sck_s;
    logic                  w_mosi_s, w_mosi_rise, w_mosi_fall;
    logic                  w_cs_s, w_cs_rise, w_cs_fall;
    logic                  w_unused_edges;
    logic                  w_abort, w_cmd_done, w_frame_done;
    logic [3:0]            r_cnt;
    logic [c_BYTE_BITS-2:0] r_shift;
    logic                  r_rw;
    logic [c_ADDR_W-1:0]   r_addr, w_cmd_addr;
    logic [7:0]            r_tx, w_rd_byte, w_data_byte;
    logic                  r_miso;
    logic [SYNC_STAGES:0]  r_flush;
    logic [7:0]            r_regs [NREG];

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_LEVEL(1'b0)) u_sync_sck (
        .CLK(CLK), .rst_n(rst_n), .din(spi_sck),
        .dout(w_sck_s), .rise(w_sck_rise), .fall(w_sck_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_LEVEL(1'b0)) u_sync_mosi (
        .CLK(CLK), .rst_n(rst_n), .din(spi_mosi),
        .dout(w_mosi_s), .rise(w_mosi_rise), .fall(w_mosi_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_LEVEL(1'b1)) u_sync_cs (
        .CLK(CLK), .rst_n(rst_n), .din(spi_cs),
        .dout(w_cs_s), .rise(w_cs_rise), .fall(w_cs_fall)
    );

    assign w_unused_edges = w_mosi_rise | w_mosi_fall | w_cs_rise | w_sck_s;

    assign w_cmd_addr  = {r_shift[c_ADDR_W-2:0], w_mosi_s};
    assign w_data_byte = {r_shift, w_mosi_s};
    assign w_rd_byte   = addr_ok(w_cmd_addr, NREG) ? r_regs[w_cmd_addr[c_IDX_W-1:0]] : 8'h00;
    assign lcl_rdata   = addr_ok(lcl_addr, NREG) ? r_regs[lcl_addr[c_IDX_W-1:0]] : 8'h00;
    assign spi_miso_oe  = ~w_cs_s;
    assign spi_miso_out = r_miso;

    always_ff @(posedge CLK) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Checking cs before sck makes a simultaneous deassertion win over a rising edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_abort      = 1'b0;
        w_cmd_done   = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall && r_flush[SYNC_STAGES]) w_state_nxt = ST_CMD;
            end
            ST_CMD: begin
                if (w_cs_s) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_sck_rise && r_cnt == c_CMD_LAST) begin
                    w_cmd_done  = 1'b1;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_cs_s) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_sck_rise && r_cnt == c_FRAME_LAST) begin
                    w_frame_done = 1'b1;
                    w_state_nxt  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_cs_s) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // r_flush keeps the synchronizer's post-reset settling from looking like a cs fall.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_flush   <= '0;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_tx      <= '0;
            r_miso    <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_valid  <= 1'b0;
            frame_err <= 1'b0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= RST_VAL;
        end else begin
            r_flush   <= {r_flush[SYNC_STAGES-1:0], 1'b1};
            wr_valid  <= 1'b0;
            rd_valid  <= 1'b0;
            frame_err <= w_abort;

            if (r_state == ST_IDLE && w_state_nxt == ST_CMD) r_cnt <= '0;

            if ((r_state == ST_CMD || r_state == ST_DATA) && !w_abort && w_sck_rise) begin
                r_shift <= w_data_byte[c_BYTE_BITS-2:0];
                r_cnt   <= r_cnt + 4'd1;
            end

            if (w_cmd_done) begin
                r_rw   <= r_shift[c_RW_POS-1];
                r_addr <= w_cmd_addr;
                if (r_shift[c_RW_POS-1]) begin
                    r_tx     <= w_rd_byte;
                    rd_valid <= 1'b1;
                end
            end

            if (w_frame_done && !r_rw && addr_ok(r_addr, NREG)) begin
                r_regs[r_addr[c_IDX_W-1:0]] <= w_data_byte;
                wr_valid <= 1'b1;
                wr_addr  <= r_addr;
                wr_data  <= w_data_byte;
            end

            if (r_state == ST_DATA && r_rw && !w_abort && !w_frame_done) begin
                if (w_sck_fall) begin
                    r_miso <= r_tx[7];
                    r_tx   <= {r_tx[6:0], 1'b0};
                end
            end else begin
                r_miso <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rf.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_slave_rf
// Brief   : Directed self-checking bench for spi_slave_rf.
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_slave_rf;

    localparam logic [7:0] c_RST = 8'h3C;
    localparam int         c_HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n, spi_sck, spi_mosi, spi_cs;
    logic       spi_miso_out, spi_miso_oe, wr_valid, rd_valid, frame_err;
    logic [6:0] wr_addr, lcl_addr;
    logic [7:0] wr_data, lcl_rdata;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
    logic [6:0] last_addr = '0;
    logic [7:0] last_data = '0;
    logic [7:0] rx0, rx1;
    int wr0, rd0, er0;

    always #5 clk = ~clk;

    spi_slave_rf #(.NREG(16), .RST_VAL(c_RST), .SYNC_STAGES(2)) dut (
        .CLK(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_cs(spi_cs), .spi_miso_out(spi_miso_out), .spi_miso_oe(spi_miso_oe),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .frame_err(frame_err),
        .lcl_addr(lcl_addr), .lcl_rdata(lcl_rdata)
    );

    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt++;
            last_addr = wr_addr;
            last_data = wr_data;
        end
        if (rd_valid)  rd_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            clks(c_HALF);
            spi_sck = 1'b1;
            rx[i] = spi_miso_out;
            clks(c_HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] b0, input logic [7:0] b1,
                         output logic [7:0] r0, output logic [7:0] r1);
        spi_cs = 1'b0;
        clks(c_HALF);
        send_bits(b0, 8, r0);
        send_bits(b1, 8, r1);
        clks(c_HALF);
        spi_cs = 1'b1;
        clks(2 * c_HALF);
    endtask

    task automatic peek(input logic [6:0] a, input string tag, input logic [7:0] exp);
        lcl_addr = a;
        #1;
        chk(tag, {24'd0, lcl_rdata}, {24'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0; spi_sck = 1'b0; spi_mosi = 1'b0; spi_cs = 1'b1; lcl_addr = '0;
        clks(5);
        chk("rst_oe",   {31'd0, spi_miso_oe},  32'd0);
        chk("rst_miso", {31'd0, spi_miso_out}, 32'd0);
        chk("rst_wrv",  {31'd0, wr_valid},     32'd0);
        rst_n = 1'b1;
        clks(5);
        peek(7'd3, "rst_reg3", c_RST);

        // Write 0xA5 to register 3
        wr0 = wr_cnt;
        frame(8'h03, 8'hA5, rx0, rx1);
        chk("wr_pulses", wr_cnt - wr0, 32'd1);
        chk("wr_addr",   {25'd0, last_addr}, 32'd3);
        chk("wr_data",   {24'd0, last_data}, 32'hA5);
        peek(7'd3, "wr_reg3", 8'hA5);

        // Read register 3 back
        wr0 = wr_cnt; rd0 = rd_cnt;
        spi_cs = 1'b0;
        clks(c_HALF);
        chk("oe_active", {31'd0, spi_miso_oe}, 32'd1);
        send_bits(8'h83, 8, rx0);
        send_bits(8'h00, 8, rx1);
        clks(c_HALF);
        spi_cs = 1'b1;
        clks(2 * c_HALF);
        chk("rd_cmd_miso", {24'd0, rx0}, 32'h00);
        chk("rd_data",     {24'd0, rx1}, 32'hA5);
        chk("rd_pulses",   rd_cnt - rd0, 32'd1);
        chk("rd_no_wr",    wr_cnt - wr0, 32'd0);
        chk("oe_idle",     {31'd0, spi_miso_oe}, 32'd0);

        // Out-of-range write then read
        wr0 = wr_cnt;
        frame(8'h20, 8'h5A, rx0, rx1);
        chk("oor_no_wr", wr_cnt - wr0, 32'd0);
        frame(8'hA0, 8'h00, rx0, rx1);
        chk("oor_rd", {24'd0, rx1}, 32'h00);
        peek(7'd3,  "oor_reg3", 8'hA5);
        peek(7'd0,  "oor_reg0", c_RST);
        peek(7'h20, "oor_lcl",  8'h00);

        // Abort after 5 bits, then a good frame
        er0 = err_cnt; wr0 = wr_cnt;
        spi_cs = 1'b0;
        clks(c_HALF);
        send_bits(8'h03, 5, rx0);
        spi_cs = 1'b1;
        clks(4 * c_HALF);
        chk("abort_err",  err_cnt - er0, 32'd1);
        chk("abort_nowr", wr_cnt - wr0, 32'd0);
        peek(7'd3, "abort_reg3", 8'hA5);
        frame(8'h03, 8'h77, rx0, rx1);
        chk("post_abort_wr", wr_cnt - wr0, 32'd1);
        peek(7'd3, "post_abort_reg3", 8'h77);

        // Reset in the middle of a write data byte
        er0 = err_cnt; wr0 = wr_cnt;
        spi_cs = 1'b0;
        clks(c_HALF);
        send_bits(8'h05, 8, rx0);
        send_bits(8'hFF, 3, rx1);
        rst_n = 1'b0;
        clks(4);
        chk("mid_rst_oe", {31'd0, spi_miso_oe}, 32'd0);
        rst_n = 1'b1;
        send_bits(8'hFF, 5, rx1);
        clks(c_HALF);
        spi_cs = 1'b1;
        clks(2 * c_HALF);
        chk("mid_rst_nowr",  wr_cnt - wr0, 32'd0);
        chk("mid_rst_noerr", err_cnt - er0, 32'd0);
        peek(7'd3, "mid_rst_reg3", c_RST);
        peek(7'd5, "mid_rst_reg5", c_RST);
        frame(8'h05, 8'h99, rx0, rx1);
        chk("post_rst_wr", wr_cnt - wr0, 32'd1);
        peek(7'd5, "post_rst_reg5", 8'h99);

        // Back-to-back writes separated by one sck period of cs high
        wr0 = wr_cnt;
        frame(8'h01, 8'h11, rx0, rx1);
        frame(8'h02, 8'h22, rx0, rx1);
        chk("b2b_pulses", wr_cnt - wr0, 32'd2);
        chk("b2b_last_addr", {25'd0, last_addr}, 32'd2);
        peek(7'd1, "b2b_reg1", 8'h11);
        peek(7'd2, "b2b_reg2", 8'h22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
